// File: rtl/laser_palette_pkg.sv
// rtl/laser_palette_pkg.sv - shared types and laser palette constants
package laser_palette_pkg;
    typedef logic [11:0] rgb12_t;
    typedef logic [4:0]  pal_idx_t;

    typedef enum logic [1:0] {SEL_NONE, SEL_PIX, SEL_HST} sel_e;

    // Palette slots of the red, yellow, green and orange laser strings
    localparam pal_idx_t LASER_IDX [0:3] = '{5'd5, 5'd7, 5'd17, 5'd21};
    localparam pal_idx_t FLASH_IDX = 5'd10;
endpackage

// File: rtl/laser_blink_gen.sv
// rtl/laser_blink_gen.sv - blink phase generator and beam-break synchronisers
module laser_blink_gen #(
    parameter int NUM_LASERS   = 4,
    parameter int BLINK_PERIOD = 6250000
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic [NUM_LASERS-1:0] beam_broken,
    output logic                  phase,
    output logic [NUM_LASERS-1:0] bb_s
);
    localparam int CW = $clog2(BLINK_PERIOD);

    logic [CW-1:0]         cnt;
    logic [NUM_LASERS-1:0] bb_meta;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt     <= '0;
            phase   <= 1'b0;
            bb_meta <= '0;
            bb_s    <= '0;
        end else begin
            bb_meta <= beam_broken;
            bb_s    <= bb_meta;
            if (cnt == CW'(BLINK_PERIOD - 1)) begin
                cnt   <= '0;
                phase <= ~phase;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/laser_palette_sched.sv
// rtl/laser_palette_sched.sv - time-shares the palette between pixel and host ports
module laser_palette_sched
    import laser_palette_pkg::*;
#(
    parameter int NUM_LASERS   = 4,
    parameter int BLINK_PERIOD = 6250000,
    parameter int STARVE_LIMIT = 1024
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  pix_valid,
    input  logic [4:0]            pix_index,
    output logic [11:0]           pix_rgb,
    output logic                  pix_rgb_valid,
    input  logic                  hst_valid,
    output logic                  hst_ready,
    input  logic [4:0]            hst_index,
    output logic [11:0]           hst_rgb,
    output logic                  hst_rgb_valid,
    output logic                  hst_starved,
    input  logic [NUM_LASERS-1:0] beam_broken,
    output logic [4:0]            pal_index,
    input  logic [11:0]           pal_rgb
);
    localparam int WW = $clog2(STARVE_LIMIT + 1);

    logic                  phase;
    logic [NUM_LASERS-1:0] bb_s;
    sel_e                  grant;
    sel_e                  s1_sel;
    pal_idx_t              grant_index;
    pal_idx_t              s1_index;
    logic [WW-1:0]         wait_cnt;
    logic [WW-1:0]         wait_next;
    logic                  hst_xfer;

    laser_blink_gen #(
        .NUM_LASERS  (NUM_LASERS),
        .BLINK_PERIOD(BLINK_PERIOD)
    ) u_blink (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .beam_broken(beam_broken),
        .phase      (phase),
        .bb_s       (bb_s)
    );

    // Walk from the highest laser down so the lowest matching laser decides
    function automatic pal_idx_t remap(input pal_idx_t idx, input logic ph,
                                       input logic [NUM_LASERS-1:0] bb);
        pal_idx_t r;
        r = idx;
        for (int k = NUM_LASERS - 1; k >= 0; k--)
            if (ph && bb[k] && idx == LASER_IDX[k])
                r = FLASH_IDX;
        return r;
    endfunction

    assign hst_ready = Reset_n & ~pix_valid;
    assign hst_xfer  = hst_valid & hst_ready;
    assign pal_index = s1_index;

    always_comb begin
        grant       = SEL_NONE;
        grant_index = hst_index;
        if (pix_valid) begin
            grant       = SEL_PIX;
            grant_index = remap(pix_index, phase, bb_s);
        end else if (hst_xfer) begin
            grant = SEL_HST;
        end
        wait_next = '0;
        if (hst_valid && !hst_ready)
            wait_next = (wait_cnt >= WW'(STARVE_LIMIT)) ? wait_cnt : wait_cnt + 1'b1;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_sel        <= SEL_NONE;
            s1_index      <= '0;
            pix_rgb       <= '0;
            pix_rgb_valid <= 1'b0;
            hst_rgb       <= '0;
            hst_rgb_valid <= 1'b0;
            wait_cnt      <= '0;
            hst_starved   <= 1'b0;
        end else begin
            s1_sel <= grant;
            // Holding the index while idle keeps the palette address quiet
            if (grant != SEL_NONE)
                s1_index <= grant_index;
            pix_rgb_valid <= (s1_sel == SEL_PIX);
            hst_rgb_valid <= (s1_sel == SEL_HST);
            if (s1_sel == SEL_PIX)
                pix_rgb <= pal_rgb;
            if (s1_sel == SEL_HST)
                hst_rgb <= pal_rgb;
            wait_cnt    <= wait_next;
            hst_starved <= (wait_next >= WW'(STARVE_LIMIT));
        end
    end
endmodule
